// File: rtl/acquisition_pkg.sv
// Shared types and width helpers for the triggered acquisition buffer.
package acquisition_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } acq_state_t;

  localparam int READ_LATENCY = 2;

  function automatic int calc_data_w(input int ch, input int spc, input int sw);
    return ch * spc * sw;
  endfunction

  function automatic int calc_depth(input int capacity, input int spc);
    return capacity / spc;
  endfunction

  function automatic int calc_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int calc_sel_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/acq_dpram.sv
// Simple dual-port RAM: one write port, one registered read-first read port.
module acq_dpram #(
  parameter int DATA_W = 128,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Same-address read and write in one cycle returns the old word.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/acquisition_trigger_bram.sv
// Circular pre/post-trigger capture buffer with registered word readout.
// Optional level-crossing trigger enabled by defining ACQ_LEVEL_TRIGGER_EN.
module acquisition_trigger_bram
  import acquisition_pkg::*;
#(
  parameter int ACQUISITION_BUFFER_CAPACITY = 16384,
  parameter int AXI_CHANNEL_COUNT           = 2,
  parameter int AXI_SAMPLE_WIDTH            = 16,
  parameter int AXI_SAMPLES_PER_CLOCK       = 4,
  localparam int DATA_W = calc_data_w(AXI_CHANNEL_COUNT, AXI_SAMPLES_PER_CLOCK, AXI_SAMPLE_WIDTH),
  localparam int DEPTH  = calc_depth(ACQUISITION_BUFFER_CAPACITY, AXI_SAMPLES_PER_CLOCK),
  localparam int ADDR_W = calc_addr_w(DEPTH),
  localparam int WORDS  = AXI_CHANNEL_COUNT * AXI_SAMPLES_PER_CLOCK,
  localparam int SEL_W  = calc_sel_w(WORDS)
`ifdef ACQ_LEVEL_TRIGGER_EN
  ,
  localparam int LCH_W  = calc_sel_w(AXI_CHANNEL_COUNT)
`endif
) (
  input  logic                        adcClk,
  input  logic                        adcResetN,
  input  logic                        axiValid,
  input  logic [DATA_W-1:0]           axiData,
  input  logic                        trigIn,
  input  logic                        arm,
  input  logic                        abort,
  input  logic [ADDR_W-1:0]           pretrigCount,
  input  logic [ADDR_W-1:0]           readAddress,
  input  logic [SEL_W-1:0]            readSel,
  output logic [AXI_SAMPLE_WIDTH-1:0] readData,
  output logic [2:0]                  state,
  output logic                        done,
  output logic [ADDR_W-1:0]           triggerAddress,
  output logic [ADDR_W-1:0]           startAddress,
  output logic [ADDR_W-1:0]           writeAddress
`ifdef ACQ_LEVEL_TRIGGER_EN
  ,
  input  logic                               levelEnable,
  input  logic [LCH_W-1:0]                   levelChannel,
  input  logic signed [AXI_SAMPLE_WIDTH-1:0] levelThreshold
`endif
);

  localparam logic [ADDR_W-1:0] MAX_PRE = ADDR_W'(DEPTH - 1);

  acq_state_t state_reg;
  logic [ADDR_W-1:0] pretrig_eff_reg, pre_cnt_reg, post_cnt_reg;
  logic [ADDR_W-1:0] write_addr_reg, trig_addr_reg, start_addr_reg;
  logic capturing, wr_en, trig_hit, trig_take;

  assign capturing = (state_reg == ST_PRE) || (state_reg == ST_WAIT) || (state_reg == ST_POST);
  assign wr_en     = capturing && axiValid && !abort;
  assign trig_take = (state_reg == ST_WAIT) && wr_en && trig_hit && !arm;

`ifdef ACQ_LEVEL_TRIGGER_EN
  localparam int SPC = AXI_SAMPLES_PER_CLOCK;
  logic signed [AXI_SAMPLE_WIDTH-1:0] prev_sample_reg;
  logic signed [AXI_SAMPLE_WIDTH-1:0] chan_s [SPC];
  logic [SPC-1:0] cross;
  logic level_hit;

  for (genvar gi = 0; gi < SPC; gi++) begin : g_chan
    assign chan_s[gi] = axiData[(32'(levelChannel) * SPC + gi) * AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH];
    if (gi == 0) begin : g_first
      assign cross[gi] = (chan_s[gi] >= levelThreshold) && (prev_sample_reg < levelThreshold);
    end else begin : g_rest
      assign cross[gi] = (chan_s[gi] >= levelThreshold) && (chan_s[gi-1] < levelThreshold);
    end
  end

  always_ff @(posedge adcClk or negedge adcResetN) begin
    if (!adcResetN) prev_sample_reg <= {1'b1, {(AXI_SAMPLE_WIDTH-1){1'b0}}};
    else if (axiValid) prev_sample_reg <= chan_s[SPC-1];
  end

  assign level_hit = levelEnable && (32'(levelChannel) < AXI_CHANNEL_COUNT) && (|cross);
  assign trig_hit  = trigIn || level_hit;
`else
  assign trig_hit = trigIn;
`endif

  // pretrigCount is ADDR_W wide, so it can never exceed DEPTH-1 and needs no clamp.
  always_ff @(posedge adcClk or negedge adcResetN) begin
    if (!adcResetN) begin
      state_reg       <= ST_IDLE;
      pretrig_eff_reg <= '0;
      pre_cnt_reg     <= '0;
      post_cnt_reg    <= '0;
      write_addr_reg  <= '0;
      trig_addr_reg   <= '0;
      start_addr_reg  <= '0;
    end else begin
      if (wr_en) write_addr_reg <= write_addr_reg + 1'b1;
      if (abort) begin
        state_reg <= ST_IDLE;
      end else begin
        case (state_reg)
          ST_IDLE, ST_DONE: begin
            if (arm) begin
              write_addr_reg  <= '0;
              pre_cnt_reg     <= '0;
              pretrig_eff_reg <= pretrigCount;
              state_reg       <= (pretrigCount == '0) ? ST_WAIT : ST_PRE;
            end
          end
          ST_PRE: begin
            if (wr_en) begin
              pre_cnt_reg <= pre_cnt_reg + 1'b1;
              if (pre_cnt_reg + 1'b1 == pretrig_eff_reg) state_reg <= ST_WAIT;
            end
          end
          ST_WAIT: begin
            if (trig_take) begin
              trig_addr_reg  <= write_addr_reg;
              start_addr_reg <= write_addr_reg - pretrig_eff_reg;
              // DEPTH is a power of two, so postEff-1 = DEPTH-1-pretrig = ~pretrig.
              post_cnt_reg   <= ~pretrig_eff_reg;
              state_reg      <= (pretrig_eff_reg == MAX_PRE) ? ST_DONE : ST_POST;
            end
          end
          ST_POST: begin
            if (wr_en) begin
              post_cnt_reg <= post_cnt_reg - 1'b1;
              if (post_cnt_reg == ADDR_W'(1)) state_reg <= ST_DONE;
            end
          end
          default: state_reg <= ST_IDLE;
        endcase
      end
    end
  end

  assign state          = state_reg;
  assign done           = (state_reg == ST_DONE);
  assign triggerAddress = trig_addr_reg;
  assign startAddress   = start_addr_reg;
  assign writeAddress   = write_addr_reg;

  logic [DATA_W-1:0] ram_q;
  logic [SEL_W-1:0] sel_reg;
  logic [AXI_SAMPLE_WIDTH-1:0] read_word, read_data_reg;

  acq_dpram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk     (adcClk),
    .wr_en   (wr_en),
    .wr_addr (write_addr_reg),
    .wr_data (axiData),
    .rd_addr (readAddress),
    .rd_data (ram_q)
  );

  always_comb begin
    read_word = '0;
    for (int i = 0; i < WORDS; i++) begin
      if (sel_reg == SEL_W'(i)) read_word = ram_q[i*AXI_SAMPLE_WIDTH +: AXI_SAMPLE_WIDTH];
    end
  end

  always_ff @(posedge adcClk or negedge adcResetN) begin
    if (!adcResetN) begin
      sel_reg       <= '0;
      read_data_reg <= '0;
    end else begin
      sel_reg       <= readSel;
      read_data_reg <= read_word;
    end
  end

  assign readData = read_data_reg;

endmodule
